// File: rtl/dm_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: default widths,
// the downstream read latency, FSM encoding and requester IDs.
package dm_port_arbiter_pkg;

  localparam int DM_AW        = 14;
  localparam int DM_DW        = 32;
  // Must track the main memory read pipeline depth.
  localparam int DM_RD_LAT    = 2;
  localparam int DM_FENCE_MIN = 2;

  typedef enum logic [1:0] {
    ARB        = 2'd0,
    FENCE_REQ  = 2'd1,
    FENCE_WAIT = 2'd2
  } arb_state_e;

  typedef logic req_id_t;
  localparam req_id_t CORE = 1'b0;
  localparam req_id_t LDR  = 1'b1;

endpackage

// File: rtl/dm_port_arbiter_rd_tag_pipe.sv
// Read-return ownership pipe: one {valid, owner} tag per accepted read,
// shifted every cycle so the head lines up with the returning read data.
module dm_port_arbiter_rd_tag_pipe
  import dm_port_arbiter_pkg::*;
#(
  parameter int DEPTH = DM_RD_LAT
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_push,
  input  req_id_t i_owner,
  output logic    o_head_valid,
  output req_id_t o_head_owner,
  output logic    o_empty
);

  logic    [DEPTH-1:0] valid_q, valid_d;
  req_id_t [DEPTH-1:0] owner_q, owner_d;

  // Shift every stage by one; a new tag (or a bubble) enters stage 0.
  always_comb begin
    valid_d[0] = i_push;
    owner_d[0] = i_owner;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      owner_d[i] = owner_q[i-1];
    end
  end

  // Valid bits clear on reset so in-flight returns are discarded.
  always_ff @(posedge i_clk) begin
    if (i_rst) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // Owner tags follow the valid bits.
  // NOTE: owner bits are left out of reset; they are only read when the matching valid bit is set.
  always_ff @(posedge i_clk) begin
    owner_q <= owner_d;
  end

  assign o_head_valid = valid_q[DEPTH-1];
  assign o_head_owner = owner_q[DEPTH-1];
  assign o_empty      = ~|valid_q;

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the main memory data port between the core LSU (C) and the
// boot/debug loader (L): round-robin grants gated by ready, read-return
// routing by tag, and loader-driven fence_i sequencing.
module dm_port_arbiter
  import dm_port_arbiter_pkg::*;
#(
  parameter int AW        = DM_AW,
  parameter int DW        = DM_DW,
  parameter int RD_LAT    = DM_RD_LAT,
  parameter int FENCE_MIN = DM_FENCE_MIN
) (
  input  logic          i_clk,
  input  logic          i_rst,
  // core port
  input  logic          i_c_req,
  input  logic          i_c_wen,
  input  logic [3:0]    i_c_ben,
  input  logic [AW-1:0] i_c_addr,
  input  logic [DW-1:0] i_c_wdata,
  output logic          o_c_gnt,
  output logic          o_c_rvalid,
  output logic [DW-1:0] o_c_rdata,
  // loader port
  input  logic          i_l_req,
  input  logic          i_l_wen,
  input  logic [3:0]    i_l_ben,
  input  logic [AW-1:0] i_l_addr,
  input  logic [DW-1:0] i_l_wdata,
  output logic          o_l_gnt,
  output logic          o_l_rvalid,
  output logic [DW-1:0] o_l_rdata,
  input  logic          i_l_fence,
  output logic          o_l_fence_done,
  // downstream memory port
  output logic          o_dm_ren,
  output logic          o_dm_wen,
  output logic [3:0]    o_dm_ben,
  output logic [AW-1:0] o_dm_addr,
  output logic [DW-1:0] o_dm_wdata,
  input  logic [DW-1:0] i_dm_rdata,
  output logic          o_fence_i,
  input  logic          i_ready
);

  localparam int CW = $clog2(FENCE_MIN + 2);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  req_id_t       ptr_q, ptr_d;         // requester that wins the next tie
  logic          fence_hold_q, fence_hold_d; // blocks re-arming until i_l_fence drops

  logic    c_gnt, l_gnt;
  logic    fence_i, fence_done;
  logic    head_valid, pipe_empty;
  req_id_t head_owner;

  // Next-state, grant and fence handshake decisions.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    fence_hold_d = fence_hold_q;
    c_gnt        = 1'b0;
    l_gnt        = 1'b0;
    fence_i      = 1'b0;
    fence_done   = 1'b0;

    if (!i_l_fence) fence_hold_d = 1'b0;

    unique case (state_q)
      ARB: begin
        if (i_l_fence && !fence_hold_q) begin
          // Fence wins over new grants; wait here for in-flight reads to drain.
          if (pipe_empty) state_d = FENCE_REQ;
        end else if (i_ready) begin
          if (i_c_req && (!i_l_req || ptr_q == CORE)) c_gnt = 1'b1;
          else if (i_l_req)                            l_gnt = 1'b1;
        end
      end
      FENCE_REQ: begin
        fence_i = 1'b1;
        cnt_d   = '0;
        state_d = FENCE_WAIT;
      end
      FENCE_WAIT: begin
        if (cnt_q >= CW'(FENCE_MIN)) begin
          if (i_ready) begin
            fence_done   = 1'b1;
            fence_hold_d = 1'b1;
            state_d      = ARB;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ARB;
    endcase

    // Nothing leaves the block while reset is held.
    if (i_rst) begin
      c_gnt      = 1'b0;
      l_gnt      = 1'b0;
      fence_i    = 1'b0;
      fence_done = 1'b0;
    end

    if (c_gnt) ptr_d = LDR;
    if (l_gnt) ptr_d = CORE;
  end

  // State, round-robin pointer, fence counter and re-arm guard.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (i_rst) begin
      state_q      <= ARB;
      cnt_q        <= '0;
      ptr_q        <= CORE;
      fence_hold_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      fence_hold_q <= fence_hold_d;
    end
  end

  // Steer the granted requester onto the downstream port; idle drives zeros.
  always_comb begin
    o_dm_ren   = 1'b0;
    o_dm_wen   = 1'b0;
    o_dm_ben   = '0;
    o_dm_addr  = '0;
    o_dm_wdata = '0;
    if (c_gnt) begin
      o_dm_ren   = ~i_c_wen;
      o_dm_wen   = i_c_wen;
      o_dm_ben   = i_c_ben;
      o_dm_addr  = i_c_addr;
      o_dm_wdata = i_c_wdata;
    end else if (l_gnt) begin
      o_dm_ren   = ~i_l_wen;
      o_dm_wen   = i_l_wen;
      o_dm_ben   = i_l_ben;
      o_dm_addr  = i_l_addr;
      o_dm_wdata = i_l_wdata;
    end
  end

  dm_port_arbiter_rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_tag_pipe (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_push       (o_dm_ren),
    .i_owner      (l_gnt ? LDR : CORE),
    .o_head_valid (head_valid),
    .o_head_owner (head_owner),
    .o_empty      (pipe_empty)
  );

  assign o_c_gnt        = c_gnt;
  assign o_l_gnt        = l_gnt;
  assign o_fence_i      = fence_i;
  assign o_l_fence_done = fence_done;
  assign o_c_rvalid     = head_valid && (head_owner == CORE) && !i_rst;
  assign o_l_rvalid     = head_valid && (head_owner == LDR)  && !i_rst;
  assign o_c_rdata      = i_dm_rdata;
  assign o_l_rdata      = i_dm_rdata;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: a stimulus table, directed
// multi-cycle sequences, and randomized traffic against a timeline model.
module tb_dm_port_arbiter;

  localparam int AW        = 14;
  localparam int DW        = 32;
  localparam int RD_LAT    = 2;
  localparam int FENCE_MIN = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          c_req = 1'b0, c_wen = 1'b0, l_req = 1'b0, l_wen = 1'b0;
  logic [3:0]    c_ben = '0, l_ben = '0;
  logic [AW-1:0] c_addr = '0, l_addr = '0;
  logic [DW-1:0] c_wdata = '0, l_wdata = '0, dm_rdata = '0;
  logic          l_fence = 1'b0, ready = 1'b1;
  logic          c_gnt, c_rvalid, l_gnt, l_rvalid, fence_done;
  logic [DW-1:0] c_rdata, l_rdata;
  logic          dm_ren, dm_wen, fence_i;
  logic [3:0]    dm_ben;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;

  int n_vec = 0;
  int n_bad = 0;

  dm_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .FENCE_MIN(FENCE_MIN)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_c_req(c_req), .i_c_wen(c_wen), .i_c_ben(c_ben), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
    .o_c_gnt(c_gnt), .o_c_rvalid(c_rvalid), .o_c_rdata(c_rdata),
    .i_l_req(l_req), .i_l_wen(l_wen), .i_l_ben(l_ben), .i_l_addr(l_addr), .i_l_wdata(l_wdata),
    .o_l_gnt(l_gnt), .o_l_rvalid(l_rvalid), .o_l_rdata(l_rdata),
    .i_l_fence(l_fence), .o_l_fence_done(fence_done),
    .o_dm_ren(dm_ren), .o_dm_wen(dm_wen), .o_dm_ben(dm_ben), .o_dm_addr(dm_addr),
    .o_dm_wdata(dm_wdata), .i_dm_rdata(dm_rdata), .o_fence_i(fence_i), .i_ready(ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // All non-passthrough outputs as one vector.
  function automatic logic [127:0] dut_outs();
    return 128'({c_gnt, l_gnt, c_rvalid, l_rvalid, dm_ren, dm_wen, dm_ben, dm_addr,
                 dm_wdata, fence_i, fence_done});
  endfunction

  // ---------------- reference model: timestamps and a return queue ----------------
  typedef struct { int unsigned due; bit ldr; } rd_t;
  rd_t         rq[$];
  int unsigned cyc = 0;
  int unsigned m_fence_at = 0;
  bit          m_fence_busy = 0, m_guard = 0, m_last_ldr = 1;
  bit          in_flight, g_core, g_ldr;
  logic        e_cv, e_lv, e_fi, e_dn, e_ren, e_wen;
  logic [3:0]  e_ben;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd;

  always @(negedge clk) begin
    e_cv = 0; e_lv = 0; e_fi = 0; e_dn = 0; e_ren = 0; e_wen = 0;
    e_ben = '0; e_addr = '0; e_wd = '0; g_core = 0; g_ldr = 0;
    if (rst) begin
      rq.delete();
      m_fence_busy = 0; m_guard = 0; m_last_ldr = 1;
    end else begin
      in_flight = 0;
      foreach (rq[i]) begin
        if (rq[i].due == cyc) begin
          if (rq[i].ldr) e_lv = 1; else e_cv = 1;
        end
        if (rq[i].due >= cyc) in_flight = 1;
      end
      while (rq.size() > 0 && rq[0].due <= cyc) void'(rq.pop_front());
      if (m_fence_busy) begin
        if (cyc == m_fence_at) e_fi = 1;
        else if (cyc >= m_fence_at + 1 + FENCE_MIN && ready) begin
          e_dn = 1; m_fence_busy = 0; m_guard = 1;
        end
      end else if (l_fence && !m_guard) begin
        if (!in_flight) begin m_fence_busy = 1; m_fence_at = cyc + 1; end
      end else if (ready && (c_req || l_req)) begin
        if (c_req && (!l_req || m_last_ldr)) g_core = 1; else g_ldr = 1;
        e_ren  = g_core ? !c_wen   : !l_wen;
        e_wen  = g_core ? c_wen    : l_wen;
        e_ben  = g_core ? c_ben    : l_ben;
        e_addr = g_core ? c_addr   : l_addr;
        e_wd   = g_core ? c_wdata  : l_wdata;
        if (e_ren) rq.push_back('{due: cyc + RD_LAT, ldr: g_ldr});
        m_last_ldr = g_ldr;
      end
      if (!l_fence) m_guard = 0;
    end
    check("model_outs", dut_outs(),
          128'({g_core, g_ldr, e_cv, e_lv, e_ren, e_wen, e_ben, e_addr, e_wd, e_fi, e_dn}));
    check("model_rdata", 128'({c_rdata, l_rdata}), 128'({dm_rdata, dm_rdata}));
    cyc++;
  end

  // ---------------- stimulus ----------------
  typedef struct { logic c_req, l_req, ready, e_cg, e_lg; } vec_t;
  vec_t tbl[10];

  logic [5:0] s4_rdy, s4_fi, s4_dn;
  logic [7:0] s5_fi, s5_lv, s5_dn, s5_cg;
  logic       seen_c, seen_l, seen_done;
  int         n_fences = 0;

  task automatic do_reset();
    rst = 1; c_req = 0; l_req = 0; l_fence = 0; ready = 1;
    next_cycle();
    next_cycle();
    rst = 0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    s4_rdy = 6'b100011; s4_fi = 6'b000010; s4_dn = 6'b100000;
    s5_fi  = 8'b00001000; s5_lv = 8'b00000010; s5_dn = 8'b01000000; s5_cg = 8'b10000000;

    do_reset();
    @(negedge clk);
    check("reset_idle", dut_outs(), 128'(0));
    next_cycle();

    // Table: core writes, loader reads, fixed fields; round-robin from core.
    c_wen = 1; c_ben = 4'h3; c_addr = 14'h011; c_wdata = 32'hC0C0_0001;
    l_wen = 0; l_ben = 4'hC; l_addr = 14'h022; l_wdata = 32'h1111_2222;
    for (int i = 0; i < 10; i++) begin
      c_req = tbl[i].c_req; l_req = tbl[i].l_req; ready = tbl[i].ready;
      @(negedge clk);
      check($sformatf("tbl_%0d", i),
            128'({c_gnt, l_gnt, dm_ren, dm_wen, dm_ben, dm_addr, dm_wdata}),
            tbl[i].e_cg ? 128'({2'b10, 2'b01, 4'h3, 14'h011, 32'hC0C0_0001}) :
            tbl[i].e_lg ? 128'({2'b01, 2'b10, 4'hC, 14'h022, 32'h1111_2222}) : 128'(0));
      next_cycle();
    end

    // Core read with two-cycle return.
    do_reset();
    c_req = 1; c_wen = 0; c_ben = 4'hF; c_addr = 14'h0010;
    @(negedge clk);
    check("s1_gnt", 128'({c_gnt, l_gnt, dm_ren, dm_wen, dm_addr}), 128'({4'b1010, 14'h0010}));
    next_cycle(); c_req = 0;
    @(negedge clk);
    check("s1_early", 128'({c_rvalid, l_rvalid}), 128'(0));
    next_cycle(); dm_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("s1_ret", 128'({c_rvalid, l_rvalid, c_rdata}), 128'({2'b10, 32'hDEAD_BEEF}));
    next_cycle();

    // Continuous contention alternates C,L,C,L,C,L after reset.
    do_reset();
    c_req = 1; c_wen = 1; l_req = 1; l_wen = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("s2_rr_%0d", k), 128'({c_gnt, l_gnt}), (k % 2 == 0) ? 128'(2) : 128'(1));
      next_cycle();
    end
    l_req = 0;

    // Ready low stalls a pending core write for three cycles.
    ready = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) ready = 1;
      @(negedge clk);
      check($sformatf("s3_rdy_%0d", k), 128'({c_gnt, dm_ren, dm_wen}),
            (k == 3) ? 128'(3'b101) : 128'(0));
      next_cycle();
    end
    c_req = 0;

    // Loader write then fence; core read stalls through the fence.
    l_req = 1; l_wen = 1; l_addr = 14'h0100; l_wdata = 32'h0000_0013; l_ben = 4'hF;
    @(negedge clk);
    check("s4_wr", 128'({l_gnt, dm_wen, dm_ren, dm_ben, dm_addr, dm_wdata}),
          128'({3'b110, 4'hF, 14'h0100, 32'h0000_0013}));
    next_cycle();
    l_req = 0; l_fence = 1; c_req = 1; c_wen = 0; c_addr = 14'h0020;
    for (int j = 0; j < 6; j++) begin
      ready = s4_rdy[j];
      @(negedge clk);
      check($sformatf("s4_fence_%0d", j), 128'({c_gnt, l_gnt, fence_i, fence_done}),
            128'({2'b00, s4_fi[j], s4_dn[j]}));
      next_cycle();
    end
    l_fence = 0;
    @(negedge clk);
    check("s4_after", 128'({c_gnt, fence_i}), 128'(2'b10));
    next_cycle(); c_req = 0;
    next_cycle(); next_cycle();

    // Loader read, fence next cycle: fence_i waits for the read to drain.
    l_req = 1; l_wen = 0; l_addr = 14'h0040;
    @(negedge clk);
    check("s5_rd", 128'({l_gnt, dm_ren}), 128'(2'b11));
    next_cycle();
    l_req = 0; l_fence = 1; c_req = 1; c_wen = 1; c_addr = 14'h0050;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) l_fence = 0;
      @(negedge clk);
      check($sformatf("s5_seq_%0d", k), 128'({c_gnt, l_gnt, l_rvalid, fence_i, fence_done}),
            128'({s5_cg[k], 1'b0, s5_lv[k], s5_fi[k], s5_dn[k]}));
      next_cycle();
    end
    c_req = 0;

    // Reset in FENCE_WAIT on the cycle done would have fired.
    l_fence = 1;
    for (int k = 0; k < 4; k++) begin
      ready = (k < 2) ? 1'b1 : 1'b0;
      @(negedge clk);
      if (k == 1) check("s6_fence_i", 128'(fence_i), 128'(1));
      next_cycle();
    end
    ready = 1; rst = 1;
    @(negedge clk);
    check("s6_in_rst", dut_outs(), 128'(0));
    next_cycle(); rst = 0; l_fence = 0;
    @(negedge clk);
    check("s6_post", dut_outs(), 128'(0));
    next_cycle(); c_req = 1; c_wen = 1;
    @(negedge clk);
    check("s6_arb", 128'({c_gnt, fence_i, fence_done}), 128'(3'b100));
    next_cycle();

    // Reset with a read in flight drops its rvalid.
    c_wen = 0;
    @(negedge clk);
    check("s7_gnt", 128'({c_gnt, dm_ren}), 128'(2'b11));
    next_cycle(); c_req = 0; rst = 1;
    next_cycle(); rst = 0;
    @(negedge clk);
    check("s7_drop", 128'({c_rvalid, l_rvalid}), 128'(0));
    next_cycle();

    // Randomized traffic, checked by the model every cycle.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      seen_c = c_gnt; seen_l = l_gnt; seen_done = fence_done;
      next_cycle();
      if (seen_c || !c_req) begin
        c_req = ($urandom_range(0, 3) != 0); c_wen = 1'($urandom);
        c_ben = 4'($urandom); c_addr = 14'($urandom); c_wdata = $urandom;
      end
      if (seen_l || !l_req) begin
        l_req = ($urandom_range(0, 2) == 0); l_wen = 1'($urandom);
        l_ben = 4'($urandom); l_addr = 14'($urandom); l_wdata = $urandom;
      end
      if (l_fence) begin
        if (seen_done) begin l_fence = 0; n_fences++; end
      end else if ($urandom_range(0, 39) == 0) begin
        l_fence = 1;
      end
      ready = ($urandom_range(0, 4) != 0);
      dm_rdata = $urandom;
    end
    check("rand_fences_done", 128'(n_fences > 0), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
